// File: rtl/lvds_7to1_packer.sv
// Pixel-rate packer: registers RGB/HS/VS/DE and maps them onto four 7-bit LVDS data-lane words plus the clock-lane word.
// Define LVDS_18BPP_EN for 3-lane 18bpp mode. Colours are rounded to 6 bits and lane3 is held at zero.
module lvds_7to1_packer #(
    parameter bit MAP_JEIDA = 1'b0,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CNT_W     = 12
) (
    input  logic             i_clk_65mhz,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [7:0]       i_red_data,
    input  logic [7:0]       i_gre_data,
    input  logic [7:0]       i_blu_data,
    input  logic             i_h_sync,
    input  logic             i_v_sync,
    input  logic             i_data_en,
    output logic [6:0]       o_lane0,
    output logic [6:0]       o_lane1,
    output logic [6:0]       o_lane2,
    output logic [6:0]       o_lane3,
    output logic [6:0]       o_clk_lane,
    output logic             o_locked,
    output logic             o_timing_err,
    output logic [CNT_W-1:0] o_h_total
);

    typedef enum logic [1:0] {IDLE, WAIT_VS, MEASURE, RUN} state_t;

    localparam logic [6:0]       CLK_WORD = 7'b1100011;
    localparam logic [6:0]       BLANK_L2 = {1'b0, ~VS_POL, ~HS_POL, 4'b0000};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [7:0]       red_q, gre_q, blu_q;
    logic             hs_q, vs_q, de_q, hs_d, vs_d;
    logic             hs_edge, vs_edge;
    logic [CNT_W-1:0] cnt, line_len;
    logic             hs_seen;
    logic             err_nxt, capture;
    logic [7:0]       r_c, g_c, b_c;
    logic [6:0]       pk0, pk1, pk2, pk3;

    // NOTE: every sequential process uses non-blocking assignments only.
    always_ff @(posedge i_clk_65mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            red_q <= '0;
            gre_q <= '0;
            blu_q <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            hs_d  <= ~HS_POL;
            vs_d  <= ~VS_POL;
        end else begin
            red_q <= i_red_data;
            gre_q <= i_gre_data;
            blu_q <= i_blu_data;
            hs_q  <= i_h_sync;
            vs_q  <= i_v_sync;
            de_q  <= i_data_en;
            hs_d  <= hs_q;
            vs_d  <= vs_q;
        end
    end

    assign hs_edge  = (hs_q == HS_POL) && (hs_d != HS_POL);
    assign vs_edge  = (vs_q == VS_POL) && (vs_d != VS_POL);
    assign line_len = cnt + CNT_ONE;

`ifdef LVDS_18BPP_EN
    // Round to 6 bits; a carry into bit 8 means the result would be 64, so clamp to 63.
    function automatic logic [7:0] round6(input logic [7:0] c);
        logic [8:0] sum;
        sum = {1'b0, c} + 9'd2;
        return sum[8] ? 8'd63 : {2'b00, sum[7:2]};
    endfunction

    assign r_c = round6(red_q);
    assign g_c = round6(gre_q);
    assign b_c = round6(blu_q);
`else
    assign r_c = red_q;
    assign g_c = gre_q;
    assign b_c = blu_q;
`endif

    // NOTE: each always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pk0 = {g_c[0], r_c[5:0]};
        pk1 = {b_c[1:0], g_c[5:1]};
        pk2 = {de_q, vs_q, hs_q, b_c[5:2]};
        pk3 = {1'b0, b_c[7:6], g_c[7:6], r_c[7:6]};
        if (MAP_JEIDA) begin
            pk0 = {g_c[2], r_c[7:2]};
            pk1 = {b_c[3:2], g_c[7:3]};
            pk2 = {de_q, vs_q, hs_q, b_c[7:4]};
            pk3 = {1'b0, b_c[1:0], g_c[1:0], r_c[1:0]};
        end
`ifdef LVDS_18BPP_EN
        pk3 = 7'b0000000;
`endif
    end

    always_ff @(posedge i_clk_65mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE:    if (i_enable) state_nxt = WAIT_VS;
            WAIT_VS: if (vs_edge) state_nxt = MEASURE;
            MEASURE: begin
                if (cnt == CNT_MAX) begin
                    err_nxt   = 1'b1;
                    state_nxt = WAIT_VS;
                end else if (hs_edge && hs_seen) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if ((cnt == CNT_MAX) || (hs_edge && (line_len != o_h_total))) begin
                    err_nxt   = 1'b1;
                    state_nxt = WAIT_VS;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Dropping enable overrides everything, including a pending error.
        if (!i_enable) begin
            state_nxt = IDLE;
            err_nxt   = 1'b0;
            capture   = 1'b0;
        end
    end

    // The counter only runs while measuring or checking lines, and saturates rather than wrapping.
    always_ff @(posedge i_clk_65mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            hs_seen <= 1'b0;
        end else if (state == MEASURE || state == RUN) begin
            if (hs_edge) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= line_len;
            end
            if (state == MEASURE && hs_edge) begin
                hs_seen <= 1'b1;
            end
        end else begin
            cnt     <= '0;
            hs_seen <= 1'b0;
        end
    end

    always_ff @(posedge i_clk_65mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_timing_err <= 1'b0;
            o_h_total    <= '0;
        end else begin
            o_timing_err <= err_nxt;
            if (capture) begin
                o_h_total <= line_len;
            end
        end
    end

    // Blanking follows the registered state, so the link goes blank one cycle after RUN is left.
    always_ff @(posedge i_clk_65mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_lane0 <= '0;
            o_lane1 <= '0;
            o_lane2 <= BLANK_L2;
            o_lane3 <= '0;
        end else if (state == RUN) begin
            o_lane0 <= pk0;
            o_lane1 <= pk1;
            o_lane2 <= pk2;
            o_lane3 <= pk3;
        end else begin
            o_lane0 <= '0;
            o_lane1 <= '0;
            o_lane2 <= BLANK_L2;
            o_lane3 <= '0;
        end
    end

    assign o_clk_lane = CLK_WORD;
    assign o_locked   = (state == RUN);

endmodule

// File: tb/tb_lvds_7to1_packer.sv
// Directed bench for lvds_7to1_packer: a VESA instance and a JEIDA instance share one 800-cycle-line video stream.
// Frames are shortened vertically; only the VS edge matters to the packer.
`timescale 1ns/1ps
module tb_lvds_7to1_packer;

    localparam int H_TOTAL  = 800;
    localparam int HS_WIDTH = 96;
    localparam int MARK     = 160;
    localparam logic [6:0] BLANK_L2 = 7'b0110000;
    localparam logic [6:0] CLK_WORD = 7'b1100011;

`ifdef LVDS_18BPP_EN
    localparam logic [6:0] EXP_V0 = 7'b1101001, EXP_V1 = 7'b0100111, EXP_V2 = 7'b1111100, EXP_V3 = 7'b0000000;
    localparam logic [6:0] EXP_J0 = 7'b1001010, EXP_J1 = 7'b0000001, EXP_J3 = 7'b0000000;
    localparam logic [6:0] EXP_FF_V3 = 7'b0000000, EXP_FF_J0 = 7'b0001111;
`else
    localparam logic [6:0] EXP_V0 = 7'b0100101, EXP_V1 = 7'b1111110, EXP_V2 = 7'b1110000, EXP_V3 = 7'b0110010;
    localparam logic [6:0] EXP_J0 = 7'b1101001, EXP_J1 = 7'b0000111, EXP_J3 = 7'b0110001;
    localparam logic [6:0] EXP_FF_V3 = 7'b0000011, EXP_FF_J0 = 7'b0111111;
`endif

    logic        i_clk_65mhz = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_enable = 1'b0;
    logic [7:0]  i_red_data = '0, i_gre_data = '0, i_blu_data = '0;
    logic        i_h_sync = 1'b1, i_v_sync = 1'b1, i_data_en = 1'b0;
    logic [6:0]  o_lane0, o_lane1, o_lane2, o_lane3, o_clk_lane;
    logic        o_locked, o_timing_err;
    logic [11:0] o_h_total;
    logic [6:0]  j_lane0, j_lane1, j_lane2, j_lane3, j_clk_lane;
    logic        j_locked, j_timing_err;
    logic [11:0] j_h_total;

    int checks = 0;
    int errors = 0;

    logic [7:0] pix_r = 8'hA5, pix_g = 8'h3C, pix_b = 8'hC3;
    int         first_lock_idx, first_unlock_idx, err_cycles, jerr_cycles;
    logic [6:0] pre_l0, pre_l2, cap_l0, cap_l1, cap_l2, cap_l3, cap_j0, cap_j1, cap_j3;

    lvds_7to1_packer u_vesa (
        .i_clk_65mhz(i_clk_65mhz), .i_rst_n(i_rst_n), .i_enable(i_enable),
        .i_red_data(i_red_data), .i_gre_data(i_gre_data), .i_blu_data(i_blu_data),
        .i_h_sync(i_h_sync), .i_v_sync(i_v_sync), .i_data_en(i_data_en),
        .o_lane0(o_lane0), .o_lane1(o_lane1), .o_lane2(o_lane2), .o_lane3(o_lane3),
        .o_clk_lane(o_clk_lane), .o_locked(o_locked), .o_timing_err(o_timing_err),
        .o_h_total(o_h_total)
    );

    lvds_7to1_packer #(.MAP_JEIDA(1'b1)) u_jeida (
        .i_clk_65mhz(i_clk_65mhz), .i_rst_n(i_rst_n), .i_enable(i_enable),
        .i_red_data(i_red_data), .i_gre_data(i_gre_data), .i_blu_data(i_blu_data),
        .i_h_sync(i_h_sync), .i_v_sync(i_v_sync), .i_data_en(i_data_en),
        .o_lane0(j_lane0), .o_lane1(j_lane1), .o_lane2(j_lane2), .o_lane3(j_lane3),
        .o_clk_lane(j_clk_lane), .o_locked(j_locked), .o_timing_err(j_timing_err),
        .o_h_total(j_h_total)
    );

    always #8 i_clk_65mhz = ~i_clk_65mhz;

    // One video line: HS active (low) for the first HS_WIDTH cycles, DE from MARK onwards.
    // Outputs are sampled on the falling edge before the next inputs are driven.
    task automatic drive_line(input int len, input bit vs_act, input int en_drop_idx);
        first_lock_idx   = -1;
        first_unlock_idx = -1;
        err_cycles       = 0;
        jerr_cycles      = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge i_clk_65mhz);
            if (o_locked && first_lock_idx < 0) first_lock_idx = i;
            if (!o_locked && first_unlock_idx < 0) first_unlock_idx = i;
            if (o_timing_err) err_cycles++;
            if (j_timing_err) jerr_cycles++;
            if (i == MARK + 1) begin
                pre_l0 = o_lane0;
                pre_l2 = o_lane2;
            end
            if (i == MARK + 2) begin
                cap_l0 = o_lane0; cap_l1 = o_lane1; cap_l2 = o_lane2; cap_l3 = o_lane3;
                cap_j0 = j_lane0; cap_j1 = j_lane1; cap_j3 = j_lane3;
            end
            if (i == en_drop_idx) i_enable = 1'b0;
            i_h_sync   = (i < HS_WIDTH) ? 1'b0 : 1'b1;
            i_v_sync   = vs_act ? 1'b0 : 1'b1;
            i_data_en  = (i >= MARK) && (i < MARK + 640);
            i_red_data = i_data_en ? pix_r : 8'h00;
            i_gre_data = i_data_en ? pix_g : 8'h00;
            i_blu_data = i_data_en ? pix_b : 8'h00;
        end
    endtask

    // Two VS lines then one normal line; lock must appear two samples into the third line.
    task automatic relock(input string tag);
        drive_line(H_TOTAL, 1'b1, -1);
        drive_line(H_TOTAL, 1'b1, -1);
        drive_line(H_TOTAL, 1'b0, -1);
        checks++; if (first_lock_idx !== 2) begin errors++; $display("FAIL %s_lock_idx got %0d want 2", tag, first_lock_idx); end
        checks++; if (o_h_total !== 12'd800) begin errors++; $display("FAIL %s_h_total got %0d want 800", tag, o_h_total); end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_enable = 1'b0;
        repeat (3) @(negedge i_clk_65mhz);
        checks++; if (o_lane0 !== 7'b0) begin errors++; $display("FAIL rst_lane0 got %b want 0000000", o_lane0); end
        checks++; if (o_lane1 !== 7'b0) begin errors++; $display("FAIL rst_lane1 got %b want 0000000", o_lane1); end
        checks++; if (o_lane2 !== BLANK_L2) begin errors++; $display("FAIL rst_lane2 got %b want %b", o_lane2, BLANK_L2); end
        checks++; if (o_lane3 !== 7'b0) begin errors++; $display("FAIL rst_lane3 got %b want 0000000", o_lane3); end
        checks++; if (o_clk_lane !== CLK_WORD) begin errors++; $display("FAIL rst_clk_lane got %b want %b", o_clk_lane, CLK_WORD); end
        checks++; if (j_clk_lane !== CLK_WORD) begin errors++; $display("FAIL rst_j_clk_lane got %b want %b", j_clk_lane, CLK_WORD); end
        checks++; if (o_locked !== 1'b0 || o_timing_err !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b want 00", o_locked, o_timing_err); end
        checks++; if (o_h_total !== 12'd0) begin errors++; $display("FAIL rst_h_total got %0d want 0", o_h_total); end
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk_65mhz);
        checks++; if (o_lane2 !== BLANK_L2) begin errors++; $display("FAIL rel_lane2 got %b want %b", o_lane2, BLANK_L2); end
        checks++; if (o_clk_lane !== CLK_WORD) begin errors++; $display("FAIL rel_clk_lane got %b want %b", o_clk_lane, CLK_WORD); end
        checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL rel_locked got %b want 0", o_locked); end
    endtask

    task automatic test_acquisition();
        int any_lock;
        any_lock = 0;
        i_enable = 1'b1;
        for (int l = 0; l < 3; l++) begin
            drive_line(H_TOTAL, 1'b0, -1);
            if (first_lock_idx >= 0) any_lock = 1;
        end
        checks++; if (any_lock !== 0) begin errors++; $display("FAIL acq_no_vs_lock got %0d want 0", any_lock); end
        drive_line(H_TOTAL, 1'b1, -1);
        checks++; if (first_lock_idx !== -1) begin errors++; $display("FAIL acq_vs_line_lock got %0d want -1", first_lock_idx); end
        drive_line(H_TOTAL, 1'b1, -1);
        checks++; if (first_lock_idx !== -1) begin errors++; $display("FAIL acq_first_hs_lock got %0d want -1", first_lock_idx); end
        drive_line(H_TOTAL, 1'b0, -1);
        checks++; if (first_lock_idx !== 2) begin errors++; $display("FAIL acq_lock_idx got %0d want 2", first_lock_idx); end
        checks++; if (o_h_total !== 12'd800) begin errors++; $display("FAIL acq_h_total got %0d want 800", o_h_total); end
        checks++; if (j_h_total !== 12'd800 || j_locked !== 1'b1) begin errors++; $display("FAIL acq_jeida got %0d/%b want 800/1", j_h_total, j_locked); end
    endtask

    task automatic test_vesa_packing();
        drive_line(H_TOTAL, 1'b0, -1);
        checks++; if (pre_l0 !== 7'b0 || pre_l2 !== 7'b0110000) begin errors++; $display("FAIL vesa_latency got %b/%b want 0000000/0110000", pre_l0, pre_l2); end
        checks++; if (cap_l0 !== EXP_V0) begin errors++; $display("FAIL vesa_lane0 got %b want %b", cap_l0, EXP_V0); end
        checks++; if (cap_l1 !== EXP_V1) begin errors++; $display("FAIL vesa_lane1 got %b want %b", cap_l1, EXP_V1); end
        checks++; if (cap_l2 !== EXP_V2) begin errors++; $display("FAIL vesa_lane2 got %b want %b", cap_l2, EXP_V2); end
        checks++; if (cap_l3 !== EXP_V3) begin errors++; $display("FAIL vesa_lane3 got %b want %b", cap_l3, EXP_V3); end
        checks++; if (err_cycles !== 0 || first_unlock_idx !== -1) begin errors++; $display("FAIL vesa_steady got %0d/%0d want 0/-1", err_cycles, first_unlock_idx); end
    endtask

    task automatic test_jeida_packing();
        drive_line(H_TOTAL, 1'b0, -1);
        checks++; if (cap_j0 !== EXP_J0) begin errors++; $display("FAIL jeida_lane0 got %b want %b", cap_j0, EXP_J0); end
        checks++; if (cap_j1 !== EXP_J1) begin errors++; $display("FAIL jeida_lane1 got %b want %b", cap_j1, EXP_J1); end
        checks++; if (cap_j3 !== EXP_J3) begin errors++; $display("FAIL jeida_lane3 got %b want %b", cap_j3, EXP_J3); end
    endtask

    task automatic test_18bpp();
        pix_r = 8'hFF; pix_g = 8'h00; pix_b = 8'h00;
        drive_line(H_TOTAL, 1'b0, -1);
        checks++; if (cap_l0 !== 7'b0111111) begin errors++; $display("FAIL sat_vesa_lane0 got %b want 0111111", cap_l0); end
        checks++; if (cap_l3 !== EXP_FF_V3) begin errors++; $display("FAIL sat_vesa_lane3 got %b want %b", cap_l3, EXP_FF_V3); end
        checks++; if (cap_j0 !== EXP_FF_J0) begin errors++; $display("FAIL sat_jeida_lane0 got %b want %b", cap_j0, EXP_FF_J0); end
        pix_r = 8'hA5; pix_g = 8'h3C; pix_b = 8'hC3;
    endtask

    task automatic test_line_check();
        drive_line(H_TOTAL - 1, 1'b0, -1);
        checks++; if (err_cycles !== 0) begin errors++; $display("FAIL short_line_early_err got %0d want 0", err_cycles); end
        drive_line(H_TOTAL, 1'b0, -1);
        checks++; if (err_cycles !== 1) begin errors++; $display("FAIL short_err_pulse got %0d want 1", err_cycles); end
        checks++; if (jerr_cycles !== 1) begin errors++; $display("FAIL short_jerr_pulse got %0d want 1", jerr_cycles); end
        checks++; if (first_unlock_idx !== 2) begin errors++; $display("FAIL short_unlock_idx got %0d want 2", first_unlock_idx); end
        checks++; if (cap_l0 !== 7'b0 || cap_l2 !== BLANK_L2) begin errors++; $display("FAIL short_blank got %b/%b want 0000000/%b", cap_l0, cap_l2, BLANK_L2); end
        relock("short_relock");
    endtask

    // Enable drops on the very cycle a mismatching line edge is evaluated: no error, IDLE next cycle.
    task automatic test_enable_drop();
        drive_line(H_TOTAL - 1, 1'b0, -1);
        drive_line(H_TOTAL, 1'b0, 1);
        checks++; if (err_cycles !== 0) begin errors++; $display("FAIL en_err_suppressed got %0d want 0", err_cycles); end
        checks++; if (first_unlock_idx !== 2) begin errors++; $display("FAIL en_unlock_idx got %0d want 2", first_unlock_idx); end
        checks++; if (o_h_total !== 12'd800) begin errors++; $display("FAIL en_h_total_held got %0d want 800", o_h_total); end
        checks++; if (cap_l0 !== 7'b0) begin errors++; $display("FAIL en_blank got %b want 0000000", cap_l0); end
        i_enable = 1'b1;
        relock("en_relock");
    endtask

    // Counter is cleared on the edge seen at sample 1; it reads k at sample 2+k and hits 4095 at sample 4097.
    task automatic test_overflow();
        drive_line(4200, 1'b0, -1);
        checks++; if (err_cycles !== 1) begin errors++; $display("FAIL ovf_err_pulse got %0d want 1", err_cycles); end
        checks++; if (first_unlock_idx !== 4098) begin errors++; $display("FAIL ovf_unlock_idx got %0d want 4098", first_unlock_idx); end
    endtask

    task automatic test_reset_midframe();
        int any_lock;
        any_lock = 0;
        relock("pre_reset");
        drive_line(400, 1'b0, -1);
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if (o_lane0 !== 7'b0 || o_lane2 !== BLANK_L2) begin errors++; $display("FAIL mid_rst_blank got %b/%b want 0000000/%b", o_lane0, o_lane2, BLANK_L2); end
        checks++; if (o_locked !== 1'b0 || o_h_total !== 12'd0) begin errors++; $display("FAIL mid_rst_state got %b/%0d want 0/0", o_locked, o_h_total); end
        @(negedge i_clk_65mhz);
        i_rst_n = 1'b1;
        for (int l = 0; l < 2; l++) begin
            drive_line(H_TOTAL, 1'b0, -1);
            if (first_lock_idx >= 0) any_lock = 1;
        end
        checks++; if (any_lock !== 0) begin errors++; $display("FAIL mid_rst_no_vs_lock got %0d want 0", any_lock); end
        relock("post_reset");
    endtask

    initial begin
        test_reset();
        test_acquisition();
        test_vesa_packing();
        test_jeida_packing();
        test_18bpp();
        test_line_check();
        test_enable_drop();
        test_overflow();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lvds_7to1_packer.md
Name: lvds_7to1_packer

Overview:
- Pixel-rate stage directly downstream of the video timing/pattern generator.
- Registers 24-bit RGB plus HS/VS/DE and maps them into four 7-bit LVDS data-lane words and one clock-lane word per pixel clock, using VESA or JEIDA bit mapping; the words feed the 7:1 serializer.
- Holds the link blanked until a frame boundary.
- Monitors line length and drops out of lock on timing change.

Parameters:
- MAP_JEIDA, 0, 0 = VESA mapping, 1 = JEIDA mapping.
- HS_POL, 0, HS active level (0 = active low).
- VS_POL, 0, VS active level (0 = active low).
- CNT_W, 12, width of the line-length counter.

Ports:
- i_clk_65mhz  input  1  pixel clock; all logic on its rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_enable  input  1  link enable; level-sensitive.
- i_red_data  input  8  red pixel.
- i_gre_data  input  8  green pixel.
- i_blu_data  input  8  blue pixel.
- i_h_sync  input  1  horizontal sync.
- i_v_sync  input  1  vertical sync.
- i_data_en  input  1  active video.
- o_lane0  output  7  data lane 0 word; bit6 is serialized first.
- o_lane1  output  7  data lane 1 word.
- o_lane2  output  7  data lane 2 word.
- o_lane3  output  7  data lane 3 word.
- o_clk_lane  output  7  clock lane word.
- o_locked  output  1  high in RUN.
- o_timing_err  output  1  one-cycle pulse on line-length mismatch or counter overflow.
- o_h_total  output  CNT_W  reference line length captured at lock.

Behaviour:
- Reset (async, i_rst_n low):
  - Lanes carry the blank word: RGB = 0, DE = 0, HS = ~HS_POL, VS = ~VS_POL, reserved = 0.
  - o_clk_lane = 7'b1100011.
  - o_locked = 0, o_timing_err = 0, o_h_total = 0, state = IDLE.
  - All input registers clear to 0, with HS/VS at their inactive level.
- Pipeline:
  - Stage 1 registers the inputs.
  - Stage 2 registers the packed lane words.
  - Latency from input to lane output is exactly 2 cycles.
  - Edge detection uses stage 1 versus a delayed copy of stage 1.
- o_clk_lane is constant 7'b1100011 at all times, including reset release.
- VESA mapping (bit6..bit0):
  - lane0 = G0 R5 R4 R3 R2 R1 R0
  - lane1 = B1 B0 G5 G4 G3 G2 G1
  - lane2 = DE VS HS B5 B4 B3 B2
  - lane3 = 0 B7 B6 G7 G6 R7 R6
- JEIDA mapping (bit6..bit0):
  - lane0 = G2 R7 R6 R5 R4 R3 R2
  - lane1 = B3 B2 G7 G6 G5 G4 G3
  - lane2 = DE VS HS B7 B6 B5 B4
  - lane3 = 0 B1 B0 G1 G0 R1 R0
- HS/VS are passed through unmodified in RUN.
- FSM states:
  - IDLE: blank words. If i_enable = 1, go to WAIT_VS.
  - WAIT_VS: blank words. On a VS active edge, go to MEASURE and clear the counter.
  - MEASURE: blank words. The counter counts cycles between consecutive HS active edges. On the second HS active edge, capture count + 1 into o_h_total and go to RUN. The first edge only restarts the counter.
  - RUN: packed data output, o_locked = 1.
- RUN line check:
  - On each HS active edge, compare the counted line length with o_h_total.
  - On mismatch: pulse o_timing_err, go to WAIT_VS.
- Counter overflow:
  - In MEASURE or RUN, a counter reaching all-ones pulses o_timing_err and goes to WAIT_VS.
  - The counter saturates at all-ones and does not wrap.
- Enable low:
  - i_enable = 0 in any state goes to IDLE on the next cycle.
  - o_locked drops in the same cycle as the state change.
  - Enable has priority over error.
  - o_h_total holds its value.
- Output blanking follows the registered state, so a blank word appears 1 cycle after leaving RUN.
- Reset mid-frame: immediate blank, and the full reacquisition sequence is required.
- HS and VS edges in the same cycle:
  - A VS edge in WAIT_VS wins.
  - In RUN, the HS line check still runs.

Optional Feature:
- Macro LVDS_18BPP_EN selects 3-lane 18bpp mode.
- With the macro defined:
  - Each colour is rounded to 6 bits: c6 = min((c8 + 2) >> 2, 63).
  - c6 is placed in bits 5..0 of the selected mapping, with colour bits 7..6 treated as 0.
  - lane3 is constant 7'b0000000.
- Without the macro: full 24bpp behaviour as above.

Test Plan:
- Reset and clock lane: hold i_rst_n low, then release with i_enable = 0 -> lanes show the blank word (VESA lane2 = 7'b0110000 for active-low sync), o_clk_lane = 7'b1100011, o_locked = 0.
- Acquisition: 640x480 stream (H_TOTAL 800, V_TOTAL 525), enable asserted mid-frame -> no lock before the first VS active edge; o_locked rises after two further HS edges; o_h_total = 800.
- VESA packing: RUN with RGB = 24'hA5_3C_C3, DE = 1, HS/VS inactive -> 2 cycles later:
  - lane0 = 7'b0100101
  - lane1 = 7'b1111110
  - lane2 = 7'b1110000
  - lane3 = 7'b0110010
- JEIDA packing: MAP_JEIDA = 1, same pixel -> lane0 = 7'b1101001, lane3 = 7'b0110001.
- Timing error: RUN, then one line shortened to 799 cycles -> single-cycle o_timing_err, o_locked falls, blank words, relock on the next VS at o_h_total = 800.
- Enable and 18bpp:
  - i_enable dropped in RUN -> IDLE next cycle, o_h_total retained.
  - With LVDS_18BPP_EN and R = 8'hFF -> R6 = 63 (saturated), lane3 = 0.
